divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 138 +++++++++++++
 tb/tb_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// divider
//   Restoring shift-subtract divider producing one quotient bit per clock,
//   MSB first. A 2*WIDTH-bit dividend is divided by a WIDTH-bit divisor.
//   After the start is accepted, the result appears 2*WIDTH+1 cycles later.
//   A divide-by-zero request finishes one cycle after acceptance.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_i          synchronous, active-high reset
//   start_i        request pulse; operands are sampled when accepted (IDLE only)
//   dividend_i     unsigned numerator, 2*WIDTH bits
//   divisor_i      unsigned denominator, WIDTH bits
//   busy_o         high from the cycle after acceptance through the done cycle
//   done_o         one-cycle pulse; results are valid in that cycle
//   quotient_o     unsigned quotient, 2*WIDTH bits, held until the next done
//   remainder_o    unsigned remainder, WIDTH bits, held until the next done
//   div_by_zero_o  set with done when the divisor was 0, held with the results
module divider #(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [2*WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]     divisor_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]     remainder_o,
  output logic                 div_by_zero_o
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW) + 1;  // wide enough to hold the value DW

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  // Shift register: dividend bits leave at the top, quotient bits enter at the bottom.
  logic [DW-1:0]    dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic             dbz_q;

  // One iteration of the restoring step.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   dsr_ext;
  logic             fits;
  logic [WIDTH:0]   rem_iter;
  logic [DW-1:0]    dvd_iter;

  always_comb begin
    dsr_ext   = {1'b0, dsr_q};
    // The extra remainder bit holds the bit shifted out, so the compare cannot overflow.
    rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[DW-1]};
    fits      = (rem_shift >= dsr_ext);
    rem_iter  = fits ? (rem_shift - dsr_ext) : rem_shift;
    dvd_iter  = {dvd_q[DW-2:0], fits};
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (divisor_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            dvd_q <= dividend_i;
            dsr_q <= divisor_i;
            rem_q <= '0;
            cnt_q <= CW'(DW);
            // Divide-by-zero skips RUN, so its results are published right here.
            if (divisor_i == '0) begin
              quo_q <= '1;
              rmd_q <= dividend_i[WIDTH-1:0];
              dbz_q <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_q <= dvd_iter;
          rem_q <= rem_iter;
          cnt_q <= cnt_q - CW'(1);
          // Publish on the last iteration so results are valid during DONE,
          // while earlier results stay visible for the whole run.
          if (cnt_q == CW'(1)) begin
            quo_q <= dvd_iter;
            rmd_q <= rem_iter[WIDTH-1:0];
            dbz_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient_o    = quo_q;
  assign remainder_o   = rmd_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divider.sv
// tb_divider
//   Directed bench for divider (WIDTH=16): checks reset values, results,
//   latency, busy, output holding, ignored starts, reset abort and a set of
//   back-to-back operand pairs with results from a reference / and % model.
module tb_divider;

  localparam int W = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2*W-1:0]  dividend = '0;
  logic [W-1:0]    divisor = '0;
  logic            busy, done, dbz;
  logic [2*W-1:0]  quotient;
  logic [W-1:0]    remainder;

  int tests = 0;
  int fails = 0;

  // Results the bench expects the outputs to be holding between operations.
  logic [2*W-1:0]  last_q = '0;
  logic [W-1:0]    last_r = '0;
  logic            last_dz = 1'b0;

  divider #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge with the DUT idle. Issues one request and
  // follows it to done. inj > 0 pulses a stray start in that busy cycle;
  // inj_done pulses one during the done cycle. Ends at the negedge of the
  // first idle cycle after done, so calls can be chained back to back.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                        input logic [31:0] eq, input logic [15:0] er, input logic edz,
                        input int elat, input int inj, input bit inj_done, input string tag);
    int  n;
    bit  busy_ok, hold_ok;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    n = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) break;
      if (quotient !== last_q || remainder !== last_r || dbz !== last_dz) hold_ok = 1'b0;
      if (n == inj) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 16'd3;
      end
    end
    chk(n, elat, {tag, " latency"});
    chk(quotient, eq, {tag, " quotient"});
    chk({16'd0, remainder}, {16'd0, er}, {tag, " remainder"});
    chk({31'd0, dbz}, {31'd0, edz}, {tag, " div_by_zero"});
    chk({31'd0, busy_ok}, 32'd1, {tag, " busy throughout"});
    chk({31'd0, hold_ok}, 32'd1, {tag, " old results held"});
    last_q  = eq;
    last_r  = er;
    last_dz = edz;
    if (inj_done) begin
      start    = 1'b1;
      dividend = 32'd9;
      divisor  = 16'd3;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk({30'd0, busy, done}, 32'd0, {tag, " back to idle"});
    chk(quotient, eq, {tag, " quotient held"});
  endtask

  initial begin
    bit            no_done;
    logic [31:0]   ra;
    logic [15:0]   rb;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({30'd0, busy, done}, 32'd0, "reset busy/done");
    chk(quotient, 32'd0, "reset quotient");
    chk({16'd0, remainder}, 32'd0, "reset remainder");
    chk({31'd0, dbz}, 32'd0, "reset div_by_zero");
    rst = 1'b0;
    @(negedge clk);

    // Basic cases.
    run_op(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 33, 0, 1'b0, "100/7");
    run_op(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0, 33, 0, 1'b0, "max/max");
    run_op(32'd5, 16'd9, 32'd0, 16'd5, 1'b0, 33, 0, 1'b1, "5/9 start-in-done");
    run_op(32'h1234_5678, 16'd0, 32'hFFFF_FFFF, 16'h5678, 1'b1, 1, 0, 1'b0, "div0");
    run_op(32'd1000, 16'd10, 32'd100, 16'd0, 1'b0, 33, 5, 1'b0, "1000/10 stray start");

    // Nothing else follows the ignored stray start.
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    chk({31'd0, no_done}, 32'd1, "stray start not queued");
    chk(quotient, 32'd100, "1000/10 quotient holds");

    // Reset in the middle of a run aborts it.
    dividend = 32'd1000;
    divisor  = 16'd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk({30'd0, busy, done}, 32'd0, "abort busy/done");
    chk(quotient, 32'd0, "abort quotient");
    chk({15'd0, dbz, remainder}, 32'd0, "abort remainder/div_by_zero");
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) no_done = 1'b0;
    end
    chk({31'd0, no_done}, 32'd1, "abort no done");
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;
    run_op(32'd50, 16'd7, 32'd7, 16'd1, 1'b0, 33, 0, 1'b0, "50/7 after abort");

    // Reset wins over a simultaneous start.
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 32'd77;
    divisor  = 16'd5;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk({30'd0, busy, done}, 32'd0, "rst beats start");
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;

    // Back-to-back operands, each started in the first idle cycle after done.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = 16'($urandom_range(65535, 1));
      if (i == 0) rb = 16'd1;
      run_op(ra, rb, ra / {16'd0, rb}, 16'(ra % {16'd0, rb}), 1'b0, 33, 0, 1'b0,
             $sformatf("b2b %0d (%0d/%0d)", i, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
